// File: rtl/aes_ctrl_pkg.sv
// aes_ctrl_pkg: shared types and constants for the AES control sequencer.
//   aes_ctrl_state_e : sequencer FSM state encoding
//   AES_NR_*         : legal round counts for AES-128/192/256
//   nr_to_idx_w()    : minimum round-key index width for a given round count
//   nr_is_legal()    : true for the three legal round counts
package aes_ctrl_pkg;

    localparam int unsigned AES_NR_128 = 10;
    localparam int unsigned AES_NR_192 = 12;
    localparam int unsigned AES_NR_256 = 14;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_KEXP_REQ  = 3'd1,
        ST_KEXP_WAIT = 3'd2,
        ST_LOAD      = 3'd3,
        ST_ROUND     = 3'd4,
        ST_FINAL     = 3'd5,
        ST_CAPTURE   = 3'd6
    } aes_ctrl_state_e;

    // Index must represent 0..nr inclusive.
    function automatic int unsigned nr_to_idx_w(input int unsigned nr);
        return $clog2(nr + 1);
    endfunction

    function automatic bit nr_is_legal(input int unsigned nr);
        return (nr == AES_NR_128) || (nr == AES_NR_192) || (nr == AES_NR_256);
    endfunction

endpackage

// File: rtl/aes_ctrl_seq_if.sv
// aes_ctrl_seq_if: command, key-expansion, datapath-strobe and status bundle of the AES
// control sequencer.
//   slave  modport : the sequencer (consumes commands/kexp_done, drives strobes/status)
//   master modport : register file / datapath side
// Optional macro AES_CTRL_IRQ_EN adds irq_mask (to sequencer) and irq (from sequencer).
interface aes_ctrl_seq_if #(
    parameter int unsigned IDX_W = 4
) ();
    logic             cmd_start;
    logic             cmd_decrypt;
    logic             cmd_new_key;
    logic             cmd_abort;
    logic             cmd_clr;
    logic             kexp_done;
    logic             kexp_start;
    logic             dp_load;
    logic             dp_round_en;
    logic             dp_final;
    logic             dp_decrypt;
    logic [IDX_W-1:0] dp_round_idx;
    logic             res_capture;
    logic             busy;
    logic             done;
    logic             err_overrun;
`ifdef AES_CTRL_IRQ_EN
    logic             irq_mask;
    logic             irq;
`endif

    modport slave (
        input  cmd_start, cmd_decrypt, cmd_new_key, cmd_abort, cmd_clr, kexp_done,
`ifdef AES_CTRL_IRQ_EN
        input  irq_mask,
        output irq,
`endif
        output kexp_start, dp_load, dp_round_en, dp_final, dp_decrypt, dp_round_idx,
        output res_capture, busy, done, err_overrun
    );

    modport master (
        output cmd_start, cmd_decrypt, cmd_new_key, cmd_abort, cmd_clr, kexp_done,
`ifdef AES_CTRL_IRQ_EN
        output irq_mask,
        input  irq,
`endif
        input  kexp_start, dp_load, dp_round_en, dp_final, dp_decrypt, dp_round_idx,
        input  res_capture, busy, done, err_overrun
    );

endinterface

// File: rtl/aes_round_cnt.sv
// aes_round_cnt: round counter and round-key index mux for the AES sequencer.
//   clk, rst    : clock, asynchronous active-high reset
//   load        : set counter to 1 (first middle round follows)
//   inc         : advance counter by one
//   decrypt     : index direction (1 = keys consumed from NR down to 0)
//   sel_load    : present the initial-key index
//   sel_round   : present the middle-round index
//   sel_final   : present the final-round index
//   idx         : round-key index (0 when nothing selected)
//   term        : counter is on the last middle round (cnt == NR-1)
module aes_round_cnt #(
    parameter int unsigned NR    = 10,
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             inc,
    input  logic             decrypt,
    input  logic             sel_load,
    input  logic             sel_round,
    input  logic             sel_final,
    output logic [IDX_W-1:0] idx,
    output logic             term
);

    localparam logic [IDX_W-1:0] NR_IDX   = IDX_W'(NR);
    localparam logic [IDX_W-1:0] LAST_MID = IDX_W'(NR - 1);

    logic [IDX_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= IDX_W'(1);
        end else if (inc) begin
            cnt_q <= cnt_q + IDX_W'(1);
        end
    end

    assign term = (cnt_q == LAST_MID);

    // Decrypt walks the key schedule backwards, so every index is mirrored around NR.
    always_comb begin
        idx = '0;
        if (sel_load) begin
            idx = decrypt ? NR_IDX : '0;
        end else if (sel_round) begin
            idx = decrypt ? (NR_IDX - cnt_q) : cnt_q;
        end else if (sel_final) begin
            idx = decrypt ? '0 : NR_IDX;
        end
    end

endmodule

// File: rtl/aes_ctrl_seq.sv
// aes_ctrl_seq: control sequencer for the AES round datapath and key-expansion unit.
// Turns register-file commands into per-cycle datapath strobes and keeps busy/done/error
// status for bus readback.
//   hclk, hreset : clock, asynchronous active-high reset
//   bus          : aes_ctrl_seq_if.slave (commands, kexp handshake, strobes, status)
// Parameters: NR (10/12/14 rounds), IDX_W (round-key index width, must hold NR).
// Optional macro AES_CTRL_IRQ_EN adds a registered irq = (done | err_overrun) & ~irq_mask.
module aes_ctrl_seq
    import aes_ctrl_pkg::*;
#(
    parameter int unsigned NR    = AES_NR_128,
    parameter int unsigned IDX_W = 4
) (
    input logic          hclk,
    input logic          hreset,
    aes_ctrl_seq_if.slave bus
);

    if (!nr_is_legal(NR)) begin : g_bad_nr
        $error("aes_ctrl_seq: NR must be 10, 12 or 14");
    end
    if (IDX_W < nr_to_idx_w(NR)) begin : g_bad_idx_w
        $error("aes_ctrl_seq: IDX_W too narrow to hold NR");
    end

    aes_ctrl_state_e state_q, state_d;
    logic key_stale_q, key_stale_d;
    logic done_q, done_d;
    logic err_q, err_d;
    logic mode_q;

    logic             busy;
    logic             start_acc;
    logic             in_kexp;
    logic             term;
    logic [IDX_W-1:0] round_idx;

    assign busy      = (state_q != ST_IDLE);
    // Abort in IDLE has no effect on state but still swallows a simultaneous start.
    assign start_acc = (state_q == ST_IDLE) && bus.cmd_start && !bus.cmd_abort;
    assign in_kexp   = (state_q == ST_KEXP_REQ) || (state_q == ST_KEXP_WAIT);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_acc) begin
                    state_d = key_stale_q ? ST_KEXP_REQ : ST_LOAD;
                end
            end
            ST_KEXP_REQ:  state_d = ST_KEXP_WAIT;
            ST_KEXP_WAIT: if (bus.kexp_done) state_d = ST_LOAD;
            ST_LOAD:      state_d = ST_ROUND;
            ST_ROUND:     if (term) state_d = ST_FINAL;
            ST_FINAL:     state_d = ST_CAPTURE;
            ST_CAPTURE:   state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
        if (bus.cmd_abort && busy) begin
            state_d = ST_IDLE;
        end
    end

    // A kexp_done coinciding with an abort of the expansion is not trusted.
    always_comb begin
        key_stale_d = key_stale_q;
        if (bus.cmd_new_key) begin
            key_stale_d = 1'b1;
        end else if (bus.kexp_done && !(bus.cmd_abort && in_kexp)) begin
            key_stale_d = 1'b0;
        end
    end

    always_comb begin
        done_d = done_q;
        if ((state_q == ST_CAPTURE) && !bus.cmd_abort) begin
            done_d = 1'b1;
        end else if (bus.cmd_clr || start_acc) begin
            done_d = 1'b0;
        end
    end

    always_comb begin
        err_d = err_q;
        if (bus.cmd_start && busy) begin
            err_d = 1'b1;
        end else if (bus.cmd_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q     <= ST_IDLE;
            key_stale_q <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mode_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_stale_q <= key_stale_d;
            done_q      <= done_d;
            err_q       <= err_d;
            if (start_acc) begin
                mode_q <= bus.cmd_decrypt;
            end
        end
    end

    aes_round_cnt #(
        .NR    (NR),
        .IDX_W (IDX_W)
    ) u_round_cnt (
        .clk       (hclk),
        .rst       (hreset),
        .load      (state_q == ST_LOAD),
        .inc       (state_q == ST_ROUND),
        .decrypt   (mode_q),
        .sel_load  (state_q == ST_LOAD),
        .sel_round (state_q == ST_ROUND),
        .sel_final (state_q == ST_FINAL),
        .idx       (round_idx),
        .term      (term)
    );

    assign bus.kexp_start   = (state_q == ST_KEXP_REQ);
    assign bus.dp_load      = (state_q == ST_LOAD);
    assign bus.dp_round_en  = (state_q == ST_ROUND) || (state_q == ST_FINAL);
    assign bus.dp_final     = (state_q == ST_FINAL);
    assign bus.dp_decrypt   = mode_q;
    assign bus.dp_round_idx = round_idx;
    assign bus.res_capture  = (state_q == ST_CAPTURE);
    assign bus.busy         = busy;
    assign bus.done         = done_q;
    assign bus.err_overrun  = err_q;

`ifdef AES_CTRL_IRQ_EN
    logic irq_q;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= (done_q | err_q) & ~bus.irq_mask;
        end
    end

    assign bus.irq = irq_q;
`endif

endmodule

// File: tb/tb_aes_ctrl_seq.sv
// tb_aes_ctrl_seq: scoreboard bench for aes_ctrl_seq (NR=10). Stimulus pushes the expected
// strobe records; a negedge monitor pops and compares whenever any strobe is active.
module tb_aes_ctrl_seq;

    logic hclk = 1'b0;
    logic hreset;

    always #5 hclk = ~hclk;

    aes_ctrl_seq_if #(.IDX_W(4)) bus ();

    aes_ctrl_seq #(
        .NR    (10),
        .IDX_W (4)
    ) dut (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus)
    );

`ifdef AES_CTRL_IRQ_EN
    initial bus.irq_mask = 1'b0;
`endif

    typedef struct packed {
        logic       ks;
        logic       ld;
        logic       re;
        logic       fin;
        logic       dec;
        logic [3:0] idx;
        logic       cap;
    } ev_t;

    ev_t exp_q[$];
    ev_t got_ev;
    ev_t exp_ev;
    int  checks = 0;
    int  errors = 0;

    // Monitor: one record per cycle with any strobe active.
    always @(negedge hclk) begin
        if (!hreset && (bus.kexp_start || bus.dp_load || bus.dp_round_en || bus.dp_final ||
                        bus.res_capture)) begin
            got_ev = '{ks: bus.kexp_start, ld: bus.dp_load, re: bus.dp_round_en,
                       fin: bus.dp_final, dec: bus.dp_decrypt, idx: bus.dp_round_idx,
                       cap: bus.res_capture};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL strobe: unexpected record %h with nothing expected", got_ev);
            end else begin
                exp_ev = exp_q.pop_front();
                if (got_ev !== exp_ev) begin
                    errors++;
                    $display("FAIL strobe: got %h required %h at %0t", got_ev, exp_ev, $time);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic push_ev(input logic ks, input logic ld, input logic re, input logic fin,
                           input logic dec, input logic [3:0] idx, input logic cap);
        exp_q.push_back('{ks: ks, ld: ld, re: re, fin: fin, dec: dec, idx: idx, cap: cap});
    endtask

    // Expected strobes for one block with NR=10: optional kexp, load, rounds 1..nrnd,
    // optional final and capture.
    task automatic push_block(input logic dec, input logic kx, input logic ld, input int nrnd,
                              input logic fin, input logic cap);
        if (kx) push_ev(1, 0, 0, 0, dec, 4'd0, 0);
        if (ld) push_ev(0, 1, 0, 0, dec, dec ? 4'd10 : 4'd0, 0);
        for (int c = 1; c <= nrnd; c++) begin
            push_ev(0, 0, 1, 0, dec, dec ? 4'(10 - c) : 4'(c), 0);
        end
        if (fin) push_ev(0, 0, 1, 1, dec, dec ? 4'd0 : 4'd10, 0);
        if (cap) push_ev(0, 0, 0, 0, dec, 4'd0, 1);
    endtask

    task automatic start(input logic dec);
        bus.cmd_decrypt = dec;
        bus.cmd_start   = 1'b1;
        tick();
        bus.cmd_start   = 1'b0;
    endtask

    task automatic kexp_reply();
        bus.kexp_done = 1'b1;
        tick();
        bus.kexp_done = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.busy && n < 40) begin
            tick();
            n++;
        end
        chk({name, "_timeout"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        hreset          = 1'b1;
        bus.cmd_start   = 1'b0;
        bus.cmd_decrypt = 1'b0;
        bus.cmd_new_key = 1'b0;
        bus.cmd_abort   = 1'b0;
        bus.cmd_clr     = 1'b0;
        bus.kexp_done   = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_err", 32'(bus.err_overrun), 0);
        chk("rst_dec", 32'(bus.dp_decrypt), 0);
        chk("rst_strobes", 32'({bus.kexp_start, bus.dp_load, bus.dp_round_en, bus.dp_final,
                                bus.res_capture, bus.dp_round_idx}), 0);
        hreset = 1'b0;
        tick();

        // Encrypt with key expansion; kexp_done returned 5 cycles after kexp_start.
        bus.cmd_new_key = 1'b1;
        tick();
        bus.cmd_new_key = 1'b0;
        push_block(0, 1, 1, 9, 1, 1);
        start(0);
        chk("kx_busy", 32'(bus.busy), 1);
        repeat (5) tick();
        kexp_reply();
        wait_idle("kx");
        chk("kx_done", 32'(bus.done), 1);

        // Fresh key: done exactly 13 cycles after the start edge.
        push_block(0, 0, 1, 9, 1, 1);
        start(0);
        chk("lat_done_clr", 32'(bus.done), 0);
        repeat (11) tick();
        chk("lat_done_t12", 32'(bus.done), 0);
        chk("lat_busy_t12", 32'(bus.busy), 1);
        tick();
        chk("lat_done_t13", 32'(bus.done), 1);
        chk("lat_busy_t13", 32'(bus.busy), 0);

        // Decrypt.
        push_block(1, 0, 1, 9, 1, 1);
        start(1);
        chk("dec_mode", 32'(bus.dp_decrypt), 1);
        wait_idle("dec");
        chk("dec_done", 32'(bus.done), 1);

        // Overrun during ROUND; mode must not be re-latched.
        push_block(0, 0, 1, 9, 1, 1);
        start(0);
        repeat (3) tick();
        bus.cmd_decrypt = 1'b1;
        bus.cmd_start   = 1'b1;
        tick();
        bus.cmd_start   = 1'b0;
        bus.cmd_decrypt = 1'b0;
        chk("ovr_err", 32'(bus.err_overrun), 1);
        wait_idle("ovr");
        chk("ovr_done", 32'(bus.done), 1);
        chk("ovr_err_held", 32'(bus.err_overrun), 1);
        bus.cmd_clr = 1'b1;
        tick();
        bus.cmd_clr = 1'b0;
        chk("clr_done", 32'(bus.done), 0);
        chk("clr_err", 32'(bus.err_overrun), 0);

        // Abort in ROUND cycle 4, then a full block.
        push_block(0, 0, 1, 4, 0, 0);
        start(0);
        repeat (4) tick();
        bus.cmd_abort = 1'b1;
        tick();
        bus.cmd_abort = 1'b0;
        chk("abt_busy", 32'(bus.busy), 0);
        chk("abt_done", 32'(bus.done), 0);
        push_block(0, 0, 1, 9, 1, 1);
        start(0);
        wait_idle("abt_rerun");
        chk("abt_rerun_done", 32'(bus.done), 1);

        // Abort and start together in IDLE: start dropped, done kept, no error.
        bus.cmd_start = 1'b1;
        bus.cmd_abort = 1'b1;
        tick();
        bus.cmd_start = 1'b0;
        bus.cmd_abort = 1'b0;
        chk("abst_busy", 32'(bus.busy), 0);
        chk("abst_err", 32'(bus.err_overrun), 0);
        chk("abst_done", 32'(bus.done), 1);

        // Start and clr together in IDLE: start accepted.
        push_block(0, 0, 1, 9, 1, 1);
        bus.cmd_clr = 1'b1;
        start(0);
        bus.cmd_clr = 1'b0;
        chk("stclr_busy", 32'(bus.busy), 1);
        chk("stclr_done", 32'(bus.done), 0);
        wait_idle("stclr");

        // Abort in KEXP_WAIT together with kexp_done: key stays stale.
        bus.cmd_new_key = 1'b1;
        tick();
        bus.cmd_new_key = 1'b0;
        push_block(0, 1, 0, 0, 0, 0);
        start(0);
        tick();
        bus.cmd_abort = 1'b1;
        bus.kexp_done = 1'b1;
        tick();
        bus.cmd_abort = 1'b0;
        bus.kexp_done = 1'b0;
        chk("kabt_busy", 32'(bus.busy), 0);
        push_block(0, 1, 1, 9, 1, 1);
        start(0);
        tick();
        kexp_reply();
        wait_idle("kabt_rerun");
        chk("kabt_done", 32'(bus.done), 1);

        // Asynchronous reset in FINAL.
        push_block(0, 0, 1, 9, 0, 0);
        start(0);
        repeat (10) tick();
        chk("rstf_final", 32'(bus.dp_final), 1);
        chk("rstf_idx", 32'(bus.dp_round_idx), 10);
        #2;
        hreset = 1'b1;
        #1;
        chk("rstf_busy", 32'(bus.busy), 0);
        chk("rstf_done", 32'(bus.done), 0);
        chk("rstf_strobes", 32'({bus.kexp_start, bus.dp_load, bus.dp_round_en, bus.dp_final,
                                 bus.res_capture, bus.dp_round_idx, bus.dp_decrypt}), 0);
        tick();
        hreset = 1'b0;
        tick();
        push_block(0, 1, 1, 9, 1, 1);
        start(0);
        tick();
        kexp_reply();
        wait_idle("rstf_rerun");
        chk("rstf_rerun_done", 32'(bus.done), 1);

        tick();
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_ctrl_seq.md
Name: aes_ctrl_seq

Overview:
Control sequencer for the AES accelerator datapath. It sits between the AHB slave register file and the AES round datapath/key-expansion unit. It turns register-file commands (start, new key, abort) into per-cycle datapath strobes: key-expansion handshake, state load, round enables with round-key index, final round and result capture. It also maintains busy/done/error status for readback over AHB.

Parameters:
NR, 10, number of AES rounds (10/12/14 for AES-128/192/256); legal values only, others are an elaboration error
IDX_W, 4, width of round-key index output; must hold NR

Ports:
hclk  in  1  system clock, all logic rising-edge
hreset  in  1  asynchronous active-high reset
cmd_start  in  1  one-cycle pulse from register write: start one block operation
cmd_decrypt  in  1  mode, sampled only when cmd_start accepted (1 = decrypt)
cmd_new_key  in  1  one-cycle pulse: key register written, expansion required
cmd_abort  in  1  one-cycle pulse: terminate current operation
cmd_clr  in  1  one-cycle pulse: clear done and err_overrun
kexp_done  in  1  key-expansion unit finished (single-cycle pulse)
kexp_start  out  1  one-cycle pulse to key-expansion unit
dp_load  out  1  load state reg with input block XOR initial round key
dp_round_en  out  1  apply one round this cycle
dp_final  out  1  current round is final (no MixColumns)
dp_decrypt  out  1  latched mode for datapath
dp_round_idx  out  IDX_W  round-key index for this cycle
res_capture  out  1  latch datapath state into output register
busy  out  1  operation in progress
done  out  1  sticky: block complete
err_overrun  out  1  sticky: cmd_start received while busy

Behaviour:
- Reset: all outputs 0, state IDLE, key_stale=1, mode=0.
- key_stale flag: set by reset or cmd_new_key (any state); cleared on kexp_done. Set wins if both happen in the same cycle.
- FSM states: IDLE, KEXP_REQ, KEXP_WAIT, LOAD, ROUND, FINAL, CAPTURE.
- IDLE:
  - On cmd_start, latch cmd_decrypt into dp_decrypt and clear done.
  - Go to KEXP_REQ if key_stale, else LOAD.
- KEXP_REQ: kexp_start=1 for one cycle -> KEXP_WAIT.
- KEXP_WAIT: hold until kexp_done -> LOAD.
- LOAD: dp_load=1. dp_round_idx=0 (encrypt) or NR (decrypt). Round counter=1 -> ROUND.
- ROUND:
  - dp_round_en=1 each cycle.
  - dp_round_idx = cnt (encrypt) or NR-cnt (decrypt).
  - cnt increments; when cnt==NR-1 this cycle, next state FINAL.
- FINAL: dp_round_en=1, dp_final=1, idx=NR (encrypt) or 0 (decrypt) -> CAPTURE.
- CAPTURE: res_capture=1 -> IDLE; done set on the entry edge to IDLE.
- busy=1 in every state except IDLE.
- Latency, cmd_start sampled at edge T with key fresh:
  - dp_load in cycle T+1, rounds T+2..T+NR, FINAL T+NR+1, CAPTURE T+NR+2.
  - done reads 1 from T+NR+3; NR=10 gives 13 cycles.
  - A stale key adds 2 cycles plus the kexp wait.
- cmd_start while busy: ignored; err_overrun set.
- cmd_start and cmd_clr in the same cycle in IDLE: start accepted, done cleared.
- cmd_abort in any non-IDLE state:
  - Next state IDLE; no res_capture; done unchanged (stays 0).
  - If aborted in KEXP_REQ/KEXP_WAIT, key_stale stays 1 (kexp_done on that same edge is ignored).
- cmd_abort in IDLE: no effect. cmd_abort and cmd_start in the same IDLE cycle: abort wins, start dropped, no error.
- cmd_new_key while busy: current operation completes with the previously expanded key; the next start re-expands.
- kexp_done outside KEXP_WAIT: only clears key_stale; no state change.
- cmd_clr clears done and err_overrun unless set in the same cycle (set wins).
- hreset mid-operation: immediate return to reset values, key_stale=1.

Optional Feature:
AES_CTRL_IRQ_EN
- Defined:
  - Adds input irq_mask (1) and output irq (1, registered).
  - irq = (done | err_overrun) & ~irq_mask; reset 0.
  - irq asserts the cycle after done sets; it deasserts the cycle after cmd_clr.
- Undefined: neither port exists; behaviour is otherwise identical.

Decomposition:
- Package aes_ctrl_pkg:
  - state enum aes_ctrl_state_e.
  - constants AES_NR_128=10, AES_NR_192=12, AES_NR_256=14.
  - function nr_to_idx_w.
- One sub-module aes_round_cnt:
  - Loadable up-counter with terminal flag (cnt==NR-1).
  - Index mux for encrypt/decrypt direction.
  - FSM and status flags stay in aes_ctrl_seq.

Test Plan:
- Reset then cmd_new_key, cmd_start (encrypt):
  - kexp_start pulses once; bench returns kexp_done 5 cycles later.
  - dp_load follows; dp_round_idx 1..9 with dp_round_en; FINAL idx 10 with dp_final; res_capture; done=1, busy=0.
- Second cmd_start with no new key: no kexp_start; done reads 1 exactly 13 cycles after the start edge.
- cmd_decrypt=1 start: load idx 10, rounds idx 9..1, final idx 0; dp_decrypt=1 throughout.
- cmd_start during ROUND: err_overrun=1, sequence unaffected; cmd_clr clears done and err_overrun next cycle.
- cmd_abort in ROUND cycle 4: busy=0 next cycle, no res_capture, done=0; new start gives a full sequence.
- cmd_abort in KEXP_WAIT, then kexp_done: next start issues kexp_start again. hreset asserted mid-FINAL: all outputs 0 asynchronously.
